// File: rtl/ife_pkg.sv
// Shared constants, filter-select encoding and FSM state encoding for the
// 3x3 image filter engine.
package ife_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int DW    = 8;
  localparam int AW    = 14;

  typedef enum logic [1:0] {
    SEL_MIN    = 2'd0,
    SEL_MEAN   = 2'd1,
    SEL_MAX    = 2'd2,
    SEL_MEDIAN = 2'd3
  } sel_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CALC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ife_window_op.sv
// Combinational 3x3 window reduction: min, mean, max or median of nine pixels.
// Define IFE_ROUND_EN to round the mean to nearest instead of flooring.
module ife_window_op
  import ife_pkg::*;
#(
  parameter int DW = ife_pkg::DW
) (
  input  logic [9*DW-1:0] win,
  input  logic [1:0]      sel,
  output logic [DW-1:0]   result
);

  localparam int SUM_W = DW + 4;

  logic [DW-1:0]    v [9];
  logic [DW-1:0]    s [9];
  logic [DW-1:0]    mn;
  logic [DW-1:0]    mx;
  logic [DW-1:0]    tmp;
  logic [DW-1:0]    mean;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_adj;

  always_comb begin
    mn  = '0;
    mx  = '0;
    sum = '0;
    tmp = '0;
    for (int i = 0; i < 9; i++) begin
      v[i] = win[i*DW +: DW];
    end
    mn = v[0];
    mx = v[0];
    for (int i = 0; i < 9; i++) begin
      if (v[i] < mn) mn = v[i];
      if (v[i] > mx) mx = v[i];
      sum = sum + SUM_W'(v[i]);
    end
    // Bubble network; only the middle element is consumed.
    s = v;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (s[j] > s[j+1]) begin
          tmp    = s[j];
          s[j]   = s[j+1];
          s[j+1] = tmp;
        end
      end
    end
`ifdef IFE_ROUND_EN
    sum_adj = sum + SUM_W'(4);
`else
    sum_adj = sum;
`endif
    mean = DW'(sum_adj / SUM_W'(9));
    case (sel)
      SEL_MIN:  result = mn;
      SEL_MEAN: result = mean;
      SEL_MAX:  result = mx;
      default:  result = s[4];
    endcase
  end

endmodule

// File: rtl/ife_filter_engine.sv
// 3x3 neighbourhood filter engine: raster-scans the source image, fetches each
// window (reusing two columns when stepping right) and writes one result per pixel.
module ife_filter_engine
  import ife_pkg::*;
#(
  parameter int IMG_W = ife_pkg::IMG_W,
  parameter int IMG_H = ife_pkg::IMG_H,
  parameter int DW    = ife_pkg::DW,
  parameter int AW    = ife_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  input  logic [DW-1:0] data_rd,
  output logic [DW-1:0] data_wr,
  output logic [AW-1:0] addr,
  output logic          wen,
  input  logic [1:0]    sel,
  output logic [2:0]    dbg_state
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [AW-1:0] LAST_PIX = AW'(IMG_W * IMG_H - 1);

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic [1:0]    sel_q, sel_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [1:0]    fc_q, fc_d;
  logic [1:0]    fr_q, fr_d;
  logic          pend_q, pend_d;
  logic [3:0]    pend_idx_q, pend_idx_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_wr_q, data_wr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] win_q [9];
  logic [DW-1:0] win_d [9];

  logic [9*DW-1:0] win_flat;
  logic [DW-1:0]   op_res;
  logic [3:0]      slot;
  logic [AW-1:0]   nb_idx;
  logic            nb_in;
  int              nb_row;
  int              nb_col;
  logic            unused_rd;

  assign unused_rd = ^data_rd;

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 9; i++) begin
      win_flat[i*DW +: DW] = win_q[i];
    end
  end

  ife_window_op #(.DW(DW)) u_op (
    .win    (win_flat),
    .sel    (sel_q),
    .result (op_res)
  );

  // Window slot index = column*3 + row; column 2 is the rightmost.
  always_comb begin
    nb_row = int'(row_q) + int'(fr_q) - 1;
    nb_col = int'(col_q) + int'(fc_q) - 1;
    nb_in  = (nb_row >= 0) && (nb_row < IMG_H) && (nb_col >= 0) && (nb_col < IMG_W);
    nb_idx = AW'(nb_row * IMG_W + nb_col);
    slot   = 4'(int'(fc_q) * 3 + int'(fr_q));
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    sel_d      = sel_q;
    row_d      = row_q;
    col_d      = col_q;
    pix_d      = pix_q;
    fc_d       = fc_q;
    fr_d       = fr_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    iaddr_d    = iaddr_q;
    addr_d     = addr_q;
    data_wr_d  = data_wr_q;
    wen_d      = 1'b0;
    win_d      = win_q;

    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          busy_d  = 1'b1;
          sel_d   = sel;
          row_d   = '0;
          col_d   = '0;
          pix_d   = '0;
          fc_d    = 2'd1;
          fr_d    = 2'd0;
          for (int i = 0; i < 9; i++) win_d[i] = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (pend_q) win_d[pend_idx_q] = idata;
        if (fc_q != 2'd3) begin
          if (nb_in) begin
            iaddr_d    = nb_idx;
            pend_d     = 1'b1;
            pend_idx_d = slot;
          end else begin
            win_d[slot] = '0;
          end
          if (fr_q == 2'd2) begin
            fr_d = 2'd0;
            fc_d = fc_q + 2'd1;
          end else begin
            fr_d = fr_q + 2'd1;
          end
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        data_wr_d = op_res;
        addr_d    = pix_q;
        wen_d     = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (pix_q == LAST_PIX) begin
          state_d = ST_DONE;
        end else begin
          pix_d = pix_q + AW'(1);
          fr_d  = 2'd0;
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            fc_d  = 2'd1;
            for (int i = 0; i < 9; i++) win_d[i] = '0;
          end else begin
            col_d = col_q + CW'(1);
            fc_d  = 2'd2;
            for (int i = 0; i < 6; i++) win_d[i] = win_q[i+3];
          end
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      sel_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      pix_q      <= '0;
      fc_q       <= '0;
      fr_q       <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      iaddr_q    <= '0;
      addr_q     <= '0;
      data_wr_q  <= '0;
      wen_q      <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      sel_q      <= sel_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pix_q      <= pix_d;
      fc_q       <= fc_d;
      fr_q       <= fr_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      iaddr_q    <= iaddr_d;
      addr_q     <= addr_d;
      data_wr_q  <= data_wr_d;
      wen_q      <= wen_d;
      win_q      <= win_d;
    end
  end

  assign busy      = busy_q;
  assign iaddr     = iaddr_q;
  assign addr      = addr_q;
  assign data_wr   = data_wr_q;
  assign wen       = wen_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ife_filter_engine.sv
// Self-checking bench for ife_filter_engine on a reduced 16x12 image, with a
// padded-window reference model built from sorted queues.
module tb_ife_filter_engine;

  localparam int W      = 16;
  localparam int H      = 12;
  localparam int N      = W * H;
  localparam int AW     = 8;
  localparam int BUDGET = 20000;
`ifdef IFE_ROUND_EN
  localparam int RND = 4;
`else
  localparam int RND = 0;
`endif

  logic          clk;
  logic          reset;
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [7:0]    idata;
  logic [7:0]    data_rd;
  logic [7:0]    data_wr;
  logic [AW-1:0] addr;
  logic          wen;
  logic [1:0]    sel;
  logic [2:0]    dbg_state;

  logic [7:0]    img [256];
  logic [7:0]    exp_q [$];
  logic [AW-1:0] got_addr [$];
  logic [7:0]    got_data [$];
  int            total;
  int            bad;
  int            cyc;
  int            last_wr_cyc;

  ife_filter_engine #(.IMG_W(W), .IMG_H(H), .DW(8), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .busy      (busy),
    .iaddr     (iaddr),
    .idata     (idata),
    .data_rd   (data_rd),
    .data_wr   (data_wr),
    .addr      (addr),
    .wen       (wen),
    .sel       (sel),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // source ROM: data for the address presented at one edge is stable by the next
  always @(negedge clk) idata = img[iaddr];

  // result RAM monitor
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      got_addr.push_back(addr);
      got_data.push_back(data_wr);
      last_wr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_pixel(int r, int c, logic [1:0] s);
    int v [$];
    int sum;
    sum = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
          v.push_back(int'(img[(r + dr) * W + c + dc]));
        else
          v.push_back(0);
      end
    end
    foreach (v[i]) sum += v[i];
    v.sort();
    case (s)
      2'd0:    return 8'(v[0]);
      2'd1:    return 8'((sum + RND) / 9);
      2'd2:    return 8'(v[8]);
      default: return 8'(v[4]);
    endcase
  endfunction

  task automatic fill_const(input logic [7:0] val);
    for (int i = 0; i < 256; i++) img[i] = val;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_frame(input logic [1:0] s, input string tag);
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(ref_pixel(r, c, s));
    check({tag, "_wcount"}, got_addr.size(), N);
    for (int i = 0; i < got_addr.size() && i < N; i++) begin
      check($sformatf("%s_addr[%0d]", tag, i), got_addr[i], i);
      check($sformatf("%s_data[%0d]", tag, i), got_data[i], exp_q.pop_front());
    end
  endtask

  task automatic run_frame(input logic [1:0] s, input int hold, input string tag);
    int n;
    bit done;
    int fall_cyc;
    got_addr.delete();
    got_data.delete();
    @(negedge clk);
    sel   = s;
    ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy_rise"}, busy, 1);
    sel = ~s;
    repeat (hold) @(negedge clk);
    ready    = 1'b0;
    n        = 0;
    done     = 1'b0;
    fall_cyc = 0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
      if (busy === 1'b0) begin
        done     = 1'b1;
        fall_cyc = cyc;
      end
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_fall_gap"}, fall_cyc - last_wr_cyc, 2);
    check_frame(s, tag);
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [1:0] s;
    int n;
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    ready   = 1'b0;
    sel     = 2'd0;
    data_rd = 8'h00;
    fill_const(8'h00);

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wen", wen, 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_addr", addr, 0);
    check("rst_data_wr", data_wr, 0);
    reset = 1'b1;

    // max over a flat image, ready held high well past busy rising
    fill_const(8'h40);
    run_frame(2'd2, 20, "max_flat");
    check("max_flat_corner", got_data[0], 8'h40);

    // max spreads a single bright pixel into its 3x3 neighbourhood
    fill_const(8'h00);
    img[6 * W + 8] = 8'hFF;
    run_frame(2'd2, 0, "max_dot");
    check("max_dot_in", got_data[5 * W + 7], 8'hFF);
    check("max_dot_edge", got_data[7 * W + 9], 8'hFF);
    check("max_dot_out", got_data[4 * W + 8], 8'h00);

    // min: padding zeroes every border pixel
    fill_const(8'h80);
    run_frame(2'd0, 0, "min_flat");
    check("min_corner", got_data[0], 8'h00);
    check("min_interior", got_data[W + 1], 8'h80);
    check("min_last", got_data[N - 1], 8'h00);

    // mean / median windows: 1..9 scrambled at (5,5), sum 13 at (8,11), sum 14 at (2,12)
    fill_const(8'h00);
    img[4 * W + 4] = 8'd9; img[4 * W + 5] = 8'd1; img[4 * W + 6] = 8'd8;
    img[5 * W + 4] = 8'd2; img[5 * W + 5] = 8'd7; img[5 * W + 6] = 8'd3;
    img[6 * W + 4] = 8'd6; img[6 * W + 5] = 8'd4; img[6 * W + 6] = 8'd5;
    img[7 * W + 10] = 8'd5; img[7 * W + 11] = 8'd4; img[7 * W + 12] = 8'd4;
    img[1 * W + 11] = 8'd5; img[1 * W + 12] = 8'd5; img[1 * W + 13] = 8'd4;
    run_frame(2'd1, 0, "mean");
    check("mean_1to9", got_data[5 * W + 5], 8'h05);
    check("mean_sum13", got_data[8 * W + 11], 8'h01);
    check("mean_sum14", got_data[2 * W + 12], (RND != 0) ? 8'h02 : 8'h01);
    run_frame(2'd3, 0, "median");
    check("median_1to9", got_data[5 * W + 5], 8'h05);

    // randomized images and filter selects
    for (int k = 0; k < 2; k++) begin
      fill_rand();
      s = 2'($urandom_range(0, 3));
      run_frame(s, int'($urandom_range(0, 10)), $sformatf("rand%0d", k));
    end

    // reset in the middle of a frame
    fill_rand();
    got_addr.delete();
    got_data.delete();
    @(negedge clk);
    sel   = 2'($urandom_range(0, 3));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n = 0;
    while (got_addr.size() < 100 && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_reached", got_addr.size(), 100);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_wen", wen, 0);
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_writes", got_addr.size(), 100);
    check("abort_addr", addr, 0);
    check("abort_iaddr", iaddr, 0);
    reset = 1'b1;

    fill_rand();
    run_frame(2'($urandom_range(0, 3)), 0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ife_filter_engine.md
Name: ife_filter_engine

Overview:
- 3x3 neighbourhood image filter engine for a 128x128, 8-bit greyscale image.
- Reads source pixels from an external image ROM (iaddr/idata) and writes one filtered byte per pixel to an external result RAM (addr/data_wr/wen).
- Filter type is selected by the 2-bit sel input. A frame is started by the ready handshake; busy brackets the whole frame.

Parameters:
- IMG_W, 128, image width in pixels
- IMG_H, 128, image height in pixels
- DW, 8, pixel data width
- AW, 14, address width (log2 of IMG_W*IMG_H)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- ready  input  1  host request to start a frame
- busy  output  1  high from frame start until the last result is written
- iaddr  output  AW  source pixel address, raster order (row*IMG_W+col)
- idata  input  DW  source pixel; valid at the rising edge following the edge that presented iaddr (one-cycle read latency)
- data_rd  input  DW  result-RAM read data; reserved, ignored
- data_wr  output  DW  result pixel to write
- addr  output  AW  result-RAM address
- wen  output  1  1 = write data_wr to addr at this rising edge; 0 = read/idle
- sel  input  2  filter select, sampled at frame start: 0 = min, 1 = mean, 2 = max, 3 = median

Behaviour:
- Reset (reset=0) values: busy=0, wen=0, iaddr=0, addr=0, data_wr=0. The FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame immediately. No further writes occur.
- FSM states: IDLE -> FETCH -> CALC -> WRITE -> (FETCH | DONE) -> IDLE.
- IDLE: when ready=1 at a rising edge, latch sel, set busy=1 on that edge, and enter FETCH at pixel (0,0).
- ready is ignored while busy=1. The host may drop ready any time after busy rises.
- Window: the 3x3 neighbourhood centred on the current pixel.
  - Out-of-image neighbours (row or col outside 0..127) are zero padding. Such neighbours are not fetched; they contribute the value 0.
- FETCH: present neighbour addresses on iaddr one per cycle and capture idata one cycle later.
  - Reusing already-held columns when stepping right along a row is permitted.
- Result arithmetic on the 9 values:
  - min: smallest of the 9 values.
  - max: largest of the 9 values.
  - mean: floor(sum/9), with an 12-bit sum.
  - median: 5th smallest of the 9 values.
- WRITE: drive addr = pixel index, data_wr = result, wen=1 for exactly one cycle. wen=0 in every other cycle.
- Writes occur strictly in raster order, 0 to 16383, each address exactly once.
- DONE: after the write to address 16383, busy drops at the next rising edge. Return to IDLE; a new ready starts a new frame.
- Throughput: the full frame completes within 200,000 cycles of busy rising.
- Boundary examples:
  - Pixel (0,0) under min: result is 0, because of padding.
  - Pixel (0,0) under max: result is the max of its 4 in-image neighbours.

Optional Feature:
- Macro: IFE_ROUND_EN.
- Defined: mean = floor((sum+4)/9), i.e. rounded to nearest.
- Undefined: mean = floor(sum/9).
- Min, max and median are unaffected either way.

Decomposition:
- Package ife_pkg holds:
  - IMG_W, IMG_H, DW, AW constants
  - the sel encoding enum (SEL_MIN=0, SEL_MEAN=1, SEL_MAX=2, SEL_MEDIAN=3)
  - the FSM state enum
- One sub-module, ife_window_op: purely combinational. Takes the 9 pixel values and sel and returns the 8-bit result (min/max comparator tree, adder plus divide-by-9, median network).
- The top level holds the FSM, window registers, and address counters.

Test Plan:
- sel=2, image all 0x40 -> every result byte 0x40; wen pulses exactly 16384 times; busy falls after the last write.
- sel=2, single pixel (64,64)=0xFF, rest 0x00 -> addresses of rows 63..65 x cols 63..65 = 0xFF, all others 0x00.
- sel=0, image all 0x80 -> interior 0x80; all border pixels 0x00 (padding).
- sel=1, interior window values 1..9 -> 0x05.
- sel=1, window sum 13 -> 0x01 without IFE_ROUND_EN, 0x01 with it. Window sum 14 -> 0x01 without IFE_ROUND_EN, 0x02 with it.
- sel=3, window {9,1,8,2,7,3,6,4,5} -> 0x05.
- Handshake and reset:
  - ready held high across busy rise -> no restart.
  - reset pulled low at write 5000 -> busy=0, wen=0 immediately.
  - A subsequent ready -> full correct frame from address 0.
